instr_assembler: RTL
====================

// Module: instr_assembler
// PURPOSE
//  Parametrised instruction register. Assembles one INSTR_W-bit instruction from BEATS = INSTR_W/BUS_W
//  consecutive bus beats fetched from program memory. Double-buffered: a completed instruction is held
//  for the decoder while the next one assembles. Adds valid/ack handshake, back-pressure and flush.
//  Sits between the memory data bus and the controller/decoder in the CPU datapath.
// PARAMETERS
//  BUS_W      8   width of one memory beat (data port)
//  INSTR_W    16  instruction width; must be an integer multiple of BUS_W, BEATS >= 2
//  BIG_ENDIAN 1   1: first beat lands in the MSBs; 0: first beat lands in the LSBs
//  OPC_W      3   opcode field width, taken from the top OPC_W bits of instr
// PORTS
//  clk         in   1        clock, all state updates on rising edge
//  rst         in   1        asynchronous reset, active low
//  ena         in   1        beat valid: data carries an instruction beat this cycle
//  data        in   BUS_W    beat payload
//  rdy         out  1        beat accepted when ena && rdy (combinational)
//  flush       in   1        synchronous discard of partial and held instruction (branch/jump)
//  instr       out  INSTR_W  held assembled instruction (registered)
//  instr_valid out  1        instr holds an unconsumed instruction
//  instr_ack   in   1        decoder consumes instr; meaningful only when instr_valid
//  opcode      out  OPC_W    instr[INSTR_W-1 -: OPC_W], combinational from instr
//  beat_idx    out  clog2(BEATS)  index of next beat expected (0 = start of instruction)
// BEHAVIOUR
//  - Reset (rst low, async): instr=0, instr_valid=0, beat_idx=0, partial register=0.
//  - rdy = !flush && (beat_idx != BEATS-1 || !instr_valid || instr_ack).
//    Only the final beat can stall; earlier beats always fill the partial register.
//  - Accepted beat k (k<BEATS-1): stored at slot k (BIG_ENDIAN: bits [INSTR_W-1-k*BUS_W -: BUS_W],
//    else [k*BUS_W +: BUS_W]); beat_idx increments.
//  - Accepted final beat: {partial, data} ordered per BIG_ENDIAN is written to instr; instr_valid=1
//    on the next edge (latency 1 cycle from final beat); beat_idx wraps to 0.
//  - instr_ack with instr_valid and no completion this cycle: instr_valid -> 0, instr keeps its value.
//  - Simultaneous ack and final beat: new instruction replaces old, instr_valid stays 1 (no bubble).
//  - ack while instr_valid=0: ignored.
//  - ena with rdy=0: beat not accepted, no state change; source must hold data and ena.
//  - flush (priority over everything except reset): beat_idx -> 0, instr_valid -> 0, partial
//    discarded; instr value retained; beats and acks in the flush cycle are ignored.
//  - No state machine beyond beat_idx (0..BEATS-1, wraps) and the instr_valid flag.
//  - Elaboration error if INSTR_W % BUS_W != 0 or INSTR_W/BUS_W < 2 or OPC_W > INSTR_W.
// STRUCTURE
//  - Shared CPU package: BUS_W, INSTR_W, OPC_W defaults and opcode enum (HLT, SKZ, ADD, AND, XOR,
//    LDA, STO, JMP) consumed by decoder and bench.
//  - Single module; beat counter and slot write are small enough to stay inline, no sub-module.
// TESTING
//  1 Reset then beats 0xA5,0x3C (defaults) -> instr_valid=1 cycle after 2nd beat, instr=0xA53C,
//    opcode=3'b101.
//  2 BIG_ENDIAN=0, beats 0xA5,0x3C -> instr=0x3CA5.
//  3 instr_valid=1 no ack, beats 0x11,0x22 -> 0x11 accepted, rdy=0 on 0x22, instr stays;
//    ack -> 0x1122 loaded same edge, instr_valid stays 1.
//  4 After 1st beat 0x77, flush -> beat_idx=0, instr_valid=0; then 0x12,0x34 -> instr=0x1234.
//  5 BUS_W=8, INSTR_W=32, beats 0xDE,0xAD,0xBE,0xEF -> instr=0xDEADBEEF, beat_idx 0,1,2,3,0.
//  6 rst low mid-assembly (after 1 beat) -> instr=0, instr_valid=0, beat_idx=0 immediately.

Source files
------------

// File: rtl/instr_assembler_pkg.sv
// Shared CPU definitions: bus/instruction widths and the opcode set
// used by the instruction register, the decoder and the bench.
package instr_assembler_pkg;

   localparam int BUS_W_DEF   = 8;
   localparam int INSTR_W_DEF = 16;
   localparam int OPC_W_DEF   = 3;

   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_e;

endpackage

// File: rtl/instr_assembler.sv
// Double-buffered instruction register: gathers BEATS bus beats into one
// instruction and holds it for the decoder under a valid/ack handshake.
module instr_assembler
   import instr_assembler_pkg::*;
#(
   parameter int BUS_W      = BUS_W_DEF,
   parameter int INSTR_W    = INSTR_W_DEF,
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int OPC_W      = OPC_W_DEF,
   localparam int BEATS     = INSTR_W / BUS_W,
   localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena,
   input  logic [BUS_W-1:0]   data,
   output logic               rdy,
   input  logic               flush,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ack,
   output logic [OPC_W-1:0]   opcode,
   output logic [IDX_W-1:0]   beat_idx
);

   if ((INSTR_W % BUS_W) != 0 || BEATS < 2 || OPC_W > INSTR_W) begin : g_bad_cfg
      $error("instr_assembler: illegal BUS_W/INSTR_W/OPC_W combination");
   end

   logic [INSTR_W-1:0] partial_q, partial_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [INSTR_W-1:0] filled;
   logic               last;
   logic               accept;

   assign last   = (idx_q == IDX_W'(BEATS - 1));
   assign rdy    = !flush && (!last || !valid_q || instr_ack);
   assign accept = ena && rdy;

   // Partial word with the incoming beat dropped into its slot.
   always_comb begin
      filled = partial_q;
      for (int i = 0; i < BEATS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            if (BIG_ENDIAN)
               filled[(BEATS - 1 - i) * BUS_W +: BUS_W] = data;
            else
               filled[i * BUS_W +: BUS_W] = data;
         end
      end
   end

   always_comb begin
      partial_d = partial_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      idx_d     = idx_q;
      if (flush) begin
         partial_d = '0;
         valid_d   = 1'b0;
         idx_d     = '0;
      end else begin
         if (valid_q && instr_ack)
            valid_d = 1'b0;
         if (accept) begin
            if (last) begin
               instr_d = filled;
               valid_d = 1'b1;
               idx_d   = '0;
            end else begin
               partial_d = filled;
               idx_d     = idx_q + IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         partial_q <= '0;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
      end else begin
         partial_q <= partial_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
      end
   end

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign beat_idx    = idx_q;
   assign opcode      = instr_q[INSTR_W-1 -: OPC_W];

endmodule
